// File: rtl/rotate_result_fifo_pkg.sv
// Shared sizing for the rotator result FIFO: default widths and pointer sizing.
package rotate_result_fifo_pkg;

   localparam int DATA_W_DEF = 8;
   localparam int DEPTH_DEF  = 4;
   localparam int PTR_W_DEF  = $clog2(DEPTH_DEF);

   function automatic int ptr_w(input int depth);
      return $clog2(depth);
   endfunction

endpackage

// File: rtl/rotate_result_fifo_if.sv
// Producer/consumer bundle around the rotator result FIFO.
interface rotate_result_fifo_if
   import rotate_result_fifo_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int DEPTH  = DEPTH_DEF
) ();

   logic                      in_valid;
   logic [DATA_W-1:0]         in_data;
   logic                      in_lr;
   logic                      in_ready;
   logic                      out_valid;
   logic                      out_ready;
   logic [DATA_W-1:0]         out_data;
   logic                      out_lr;
   logic [ptr_w(DEPTH):0]     count;
   logic                      overflow;

   modport master (
      output in_valid, in_data, in_lr, out_ready,
      input  in_ready, out_valid, out_data, out_lr, count, overflow
   );

   modport slave (
      input  in_valid, in_data, in_lr, out_ready,
      output in_ready, out_valid, out_data, out_lr, count, overflow
   );

endinterface

// File: rtl/rotate_result_fifo_regfile.sv
// Entry storage: one synchronous write port, one asynchronous read port, no reset.
module rfifo_regfile
   import rotate_result_fifo_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int DEPTH  = DEPTH_DEF,
   localparam int AW    = ptr_w(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [DATA_W:0]   wdata,
   input  logic [AW-1:0]     raddr,
   output logic [DATA_W:0]   rdata
);

   logic [DATA_W:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/rotate_result_fifo.sv
// First-word-fall-through FIFO capturing rotator results with their direction tag.
module rotate_result_fifo
   import rotate_result_fifo_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int DEPTH  = DEPTH_DEF
) (
   input  logic                  clk,
   input  logic                  reset,
   rotate_result_fifo_if.slave   bus
);

   localparam int AW = ptr_w(DEPTH);
   localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [AW:0]     count_q;
   logic            overflow_q;
   logic            push, pop, full, empty;
   logic [DATA_W:0] head;

   assign full  = (count_q == CNT_FULL);
   assign empty = (count_q == '0);

   // Handshake flags come only from registered occupancy, so out_ready never reaches in_ready.
   assign pop  = !empty && bus.out_ready;
   assign push = bus.in_valid && (!full || pop);

   rfifo_regfile #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_regfile (
      .clk   (clk),
      .we    (push),
      .waddr (wr_ptr),
      .wdata ({bus.in_lr, bus.in_data}),
      .raddr (rd_ptr),
      .rdata (head)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)      count_q <= count_q + 1'b1;
         else if (pop && !push) count_q <= count_q - 1'b1;
         if (bus.in_valid && !push) overflow_q <= 1'b1;
      end
   end

   assign bus.in_ready  = !full;
   assign bus.out_valid = !empty;
   // Stale storage is masked so an empty FIFO always presents zeros.
   assign bus.out_data  = empty ? '0   : head[DATA_W-1:0];
   assign bus.out_lr    = empty ? 1'b0 : head[DATA_W];
   assign bus.count     = count_q;
   assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_rotate_result_fifo.sv
// Directed checks of the rotator result FIFO with hand-computed expectations.
module tb_rotate_result_fifo;
   import rotate_result_fifo_pkg::*;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   failures = 0;

   rotate_result_fifo_if #(.DATA_W(8), .DEPTH(4)) bus ();

   rotate_result_fifo #(.DATA_W(8), .DEPTH(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.in_lr     = 1'b0;
      bus.out_ready = 1'b0;

      // reset state
      reset = 1'b1; tick(); tick();
      reset = 1'b0;
      chk("rst_count", 32'(bus.count), 0);
      chk("rst_out_valid", 32'(bus.out_valid), 0);
      chk("rst_out_data", 32'(bus.out_data), 0);
      chk("rst_in_ready", 32'(bus.in_ready), 1);
      chk("rst_overflow", 32'(bus.overflow), 0);

      // single push, one-cycle latency
      bus.in_valid = 1'b1; bus.in_data = 8'hA5; bus.in_lr = 1'b0;
      tick();
      bus.in_valid = 1'b0;
      chk("a5_out_valid", 32'(bus.out_valid), 1);
      chk("a5_out_data", 32'(bus.out_data), 32'hA5);
      chk("a5_out_lr", 32'(bus.out_lr), 0);
      chk("a5_count", 32'(bus.count), 1);
      bus.out_ready = 1'b1; tick(); bus.out_ready = 1'b0;
      chk("a5_pop_count", 32'(bus.count), 0);

      // pop at count=1 with no push
      bus.in_valid = 1'b1; bus.in_data = 8'h3C; bus.in_lr = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      chk("3c_out_lr", 32'(bus.out_lr), 1);
      bus.out_ready = 1'b1; tick(); bus.out_ready = 1'b0;
      chk("3c_pop_out_valid", 32'(bus.out_valid), 0);
      chk("3c_pop_out_data", 32'(bus.out_data), 0);
      chk("3c_pop_out_lr", 32'(bus.out_lr), 0);
      chk("3c_pop_in_ready", 32'(bus.in_ready), 1);

      // out_ready while empty does nothing
      bus.out_ready = 1'b1; tick();
      chk("empty_pop_count", 32'(bus.count), 0);

      // push at count=0 with out_ready=1: no pop that cycle
      bus.in_valid = 1'b1; bus.in_data = 8'h11; bus.in_lr = 1'b0;
      tick();
      bus.in_valid = 1'b0;
      chk("push_empty_rdy_count", 32'(bus.count), 1);
      chk("push_empty_rdy_data", 32'(bus.out_data), 32'h11);
      tick();
      bus.out_ready = 1'b0;
      chk("push_empty_rdy_drain", 32'(bus.count), 0);

      // fill to DEPTH
      for (int i = 1; i <= 4; i++) begin
         bus.in_valid = 1'b1; bus.in_data = 8'(i); bus.in_lr = 1'(i & 1);
         tick();
      end
      chk("full_count", 32'(bus.count), 4);
      chk("full_in_ready", 32'(bus.in_ready), 0);
      chk("full_head", 32'(bus.out_data), 32'h01);
      chk("full_overflow_clear", 32'(bus.overflow), 0);

      // dropped push at full
      bus.in_data = 8'h05; bus.in_lr = 1'b1;
      tick();
      chk("drop_overflow", 32'(bus.overflow), 1);
      chk("drop_count", 32'(bus.count), 4);
      chk("drop_head", 32'(bus.out_data), 32'h01);

      // simultaneous push/pop at full
      bus.in_data = 8'h77; bus.in_lr = 1'b1; bus.out_ready = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      chk("pp_full_count", 32'(bus.count), 4);
      chk("pp_full_head", 32'(bus.out_data), 32'h02);
      chk("pp_full_overflow", 32'(bus.overflow), 1);

      // drain: 02,03,04,77 with paired tags
      chk("drain0_data", 32'(bus.out_data), 32'h02);
      chk("drain0_lr", 32'(bus.out_lr), 0);
      tick();
      chk("drain_in_ready", 32'(bus.in_ready), 1);
      chk("drain1_data", 32'(bus.out_data), 32'h03);
      chk("drain1_lr", 32'(bus.out_lr), 1);
      tick();
      chk("drain2_data", 32'(bus.out_data), 32'h04);
      chk("drain2_lr", 32'(bus.out_lr), 0);
      tick();
      chk("drain3_data", 32'(bus.out_data), 32'h77);
      chk("drain3_lr", 32'(bus.out_lr), 1);
      tick();
      chk("drain_empty", 32'(bus.out_valid), 0);
      chk("overflow_sticky", 32'(bus.overflow), 1);

      // streaming: ten pairs, pointers wrap repeatedly
      for (int i = 0; i < 10; i++) begin
         bus.in_valid = 1'b1; bus.in_data = 8'(8'h80 + i); bus.in_lr = 1'(i & 1);
         tick();
         chk($sformatf("stream%0d_data", i), 32'(bus.out_data), 32'(8'h80 + i));
         chk($sformatf("stream%0d_lr", i), 32'(bus.out_lr), 32'(i & 1));
         chk($sformatf("stream%0d_count", i), 32'(bus.count), 1);
      end
      bus.in_valid = 1'b0;
      tick();
      bus.out_ready = 1'b0;
      chk("stream_end_count", 32'(bus.count), 0);

      // reset at count=3 with simultaneous push
      for (int i = 0; i < 3; i++) begin
         bus.in_valid = 1'b1; bus.in_data = 8'(8'h40 + i); bus.in_lr = 1'b1;
         tick();
      end
      chk("pre_rst_count", 32'(bus.count), 3);
      reset = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      chk("rst3_count", 32'(bus.count), 0);
      chk("rst3_out_valid", 32'(bus.out_valid), 0);
      chk("rst3_out_data", 32'(bus.out_data), 0);
      chk("rst3_overflow", 32'(bus.overflow), 0);
      reset = 1'b0;
      tick();
      chk("post_rst_count", 32'(bus.count), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
